// File: rtl/quad_counter_if.sv
// Control and readback bus between the SPI frame logic and the quadrature counter.
// The master side issues pulses; the slave (counter) returns live and frozen values.
interface quad_counter_if #(
   parameter int W = 16
);
   logic         latch;
   logic         clear;
   logic         index_arm;
   logic [W-1:0] count;
   logic [W-1:0] count_snap;
   logic         err_snap;
   logic [W-1:0] index_pos;
   logic         index_seen;
   logic         err;

   modport master (
      output latch, clear, index_arm,
      input  count, count_snap, err_snap, index_pos, index_seen, err
   );

   modport slave (
      input  latch, clear, index_arm,
      output count, count_snap, err_snap, index_pos, index_seen, err
   );
endinterface

// File: rtl/quad_counter.sv
// Quadrature encoder front end: sync + debounce A/B/Z, x4 decode into a wrapping count,
// sticky illegal-transition flag, armed index capture and a latch-frozen snapshot.
module quad_counter #(
   parameter int W   = 16,
   parameter int FLT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sample_en,
   input  logic            enc_a,
   input  logic            enc_b,
   input  logic            enc_z,
   quad_counter_if.slave   bus
);

   typedef enum logic {INIT, RUN} state_t;

   state_t       state;
   state_t       state_next;
   logic [3:0]   init_cnt;
   logic         init_load;
   logic         run;

   // Channel bit order everywhere below: [0]=A, [1]=B, [2]=Z
   logic [2:0]   s1;
   logic [2:0]   s2;
   logic [2:0]   filt;
   logic [2:0]   prev;
   logic [3:0]   fcnt [0:2];

   logic [W-1:0] count;
   logic [W-1:0] count_next;
   logic [W-1:0] count_snap;
   logic [W-1:0] index_pos;
   logic         err;
   logic         err_snap;
   logic         index_seen;
   logic         armed;
   logic         step_up;
   logic         step_dn;
   logic         illegal;
   logic         z_rise;
   logic         capture;

   function automatic logic [1:0] gray_pos(input logic a, input logic b);
      case ({a, b})
         2'b00:   gray_pos = 2'd0;
         2'b01:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_next;
         if (init_load && sample_en)
            init_cnt <= init_cnt + 4'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (sample_en && init_cnt == 4'(FLT - 1)) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      init_load = (state == INIT);
      run       = (state == RUN);
   end

   // In INIT, prev follows the directly loaded level so the first RUN clock sees no phantom edge
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         filt <= '0;
         prev <= '0;
         for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      end else begin
         s1   <= {enc_z, enc_b, enc_a};
         s2   <= s1;
         prev <= (init_load && sample_en) ? s2 : filt;
         for (int i = 0; i < 3; i++) begin
            if (sample_en) begin
               if (init_load) begin
                  filt[i] <= s2[i];
                  fcnt[i] <= '0;
               end else if (s2[i] != filt[i]) begin
                  if (fcnt[i] == 4'(FLT - 1)) begin
                     filt[i] <= s2[i];
                     fcnt[i] <= '0;
                  end else begin
                     fcnt[i] <= fcnt[i] + 4'd1;
                  end
               end else begin
                  fcnt[i] <= '0;
               end
            end
         end
      end
   end

   always_comb begin
      step_up    = 1'b0;
      step_dn    = 1'b0;
      illegal    = 1'b0;
      if (run) begin
         case (2'(gray_pos(filt[0], filt[1]) - gray_pos(prev[0], prev[1])))
            2'd1:    step_up = 1'b1;
            2'd3:    step_dn = 1'b1;
            2'd2:    illegal = 1'b1;
            default: ;
         endcase
      end
      count_next = count;
      if (step_up)
         count_next = count + W'(1);
      else if (step_dn)
         count_next = count - W'(1);
      z_rise  = run && filt[2] && !prev[2];
      capture = z_rise && armed;
   end

   // clear overrides every same-clock event except the snapshot, which sees pre-clear values
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         count_snap <= '0;
         err_snap   <= 1'b0;
         index_pos  <= '0;
         index_seen <= 1'b0;
         err        <= 1'b0;
         armed      <= 1'b0;
      end else begin
         if (bus.latch) begin
            count_snap <= count;
            err_snap   <= err;
         end
         if (bus.clear) begin
            count      <= '0;
            err        <= 1'b0;
            index_seen <= 1'b0;
            armed      <= 1'b0;
         end else begin
            count <= count_next;
            if (illegal)
               err <= 1'b1;
            if (capture) begin
               index_pos  <= count_next;
               index_seen <= 1'b1;
            end
            armed <= (armed && !capture) || bus.index_arm;
         end
      end
   end

   assign bus.count      = count;
   assign bus.count_snap = count_snap;
   assign bus.err_snap   = err_snap;
   assign bus.index_pos  = index_pos;
   assign bus.index_seen = index_seen;
   assign bus.err        = err;

endmodule

// File: tb/tb_quad_counter.sv
// Self-checking bench for quad_counter: a 16-bit and a 4-bit instance share the pins; expected
// counts come from a shaft-position model that tracks the Gray phase the bench drives.
module tb_quad_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample_en = 1'b1;
   logic enc_a = 1'b0;
   logic enc_b = 1'b0;
   logic enc_z = 1'b0;
   logic latch = 1'b0;
   logic clear = 1'b0;
   logic index_arm = 1'b0;

   int checks = 0;
   int passes = 0;

   int model_count = 0;
   int pos = 0;
   bit se_mode = 1'b0;
   int se_div = 0;
   logic [1:0] gray_tab [0:3];

   quad_counter_if #(.W(16)) bus16 ();
   quad_counter_if #(.W(4))  bus4 ();

   assign bus16.latch     = latch;
   assign bus16.clear     = clear;
   assign bus16.index_arm = index_arm;
   assign bus4.latch      = latch;
   assign bus4.clear      = clear;
   assign bus4.index_arm  = index_arm;

   quad_counter #(.W(16), .FLT(3)) dut16 (
      .clk(clk), .rst(rst), .sample_en(sample_en),
      .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .bus(bus16.slave)
   );

   quad_counter #(.W(4), .FLT(3)) dut4 (
      .clk(clk), .rst(rst), .sample_en(sample_en),
      .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .bus(bus4.slave)
   );

   always #5 clk = ~clk;

   // Slow-prescaler mode: one sample_en every third clock
   always @(negedge clk) begin
      if (se_mode) begin
         sample_en = (se_div == 0);
         se_div = (se_div == 2) ? 0 : se_div + 1;
      end else begin
         sample_en = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_pins();
      enc_a = gray_tab[pos][1];
      enc_b = gray_tab[pos][0];
   endtask

   task automatic step(input int dir, input int hold);
      pos = (pos + dir) & 3;
      model_count += dir;
      drive_pins();
      tick(hold);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      model_count = 0;
   endtask

   task automatic pulse_latch();
      latch = 1'b1;
      tick(1);
      latch = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++;
      if ({bus16.count, bus16.count_snap, bus16.index_pos, bus16.err, bus16.err_snap, bus16.index_seen} !== '0)
         $display("[TB] FAIL reset_outputs: count=%h snap=%h idx=%h err=%b errsnap=%b seen=%b, required all 0",
                  bus16.count, bus16.count_snap, bus16.index_pos, bus16.err, bus16.err_snap, bus16.index_seen);
      else passes++;
      rst = 1'b0;
      tick(10);
      checks++;
      if (bus16.count !== 16'h0 || bus4.count !== 4'h0)
         $display("[TB] FAIL reset_idle_count: count16=%h count4=%h, required 0", bus16.count, bus4.count);
      else passes++;
   endtask

   task automatic test_latency();
      pos = 1;
      drive_pins();
      tick(5);
      checks++;
      if (bus16.count !== 16'h0)
         $display("[TB] FAIL latency_early: count=%h after 5 clk, required 0000", bus16.count);
      else passes++;
      tick(1);
      checks++;
      if (bus16.count !== 16'h1)
         $display("[TB] FAIL latency_edge: count=%h after 6 clk, required 0001", bus16.count);
      else passes++;
      model_count = 1;
      tick(4);
   endtask

   task automatic test_forward_reverse();
      pulse_clear();
      for (int i = 0; i < 8; i++) step(1, 10);
      checks++;
      if (bus16.count !== 16'(model_count) || model_count != 8)
         $display("[TB] FAIL fwd8: count=%h, required %h", bus16.count, 16'(model_count));
      else passes++;
      for (int i = 0; i < 8; i++) step(-1, 10);
      checks++;
      if (bus16.count !== 16'h0)
         $display("[TB] FAIL rev8: count=%h, required 0000", bus16.count);
      else passes++;
   endtask

   task automatic test_wrap();
      pulse_clear();
      step(-1, 10);
      checks++;
      if (bus16.count !== 16'hFFFF || bus4.count !== 4'hF)
         $display("[TB] FAIL wrap_under: count16=%h count4=%h, required FFFF/F", bus16.count, bus4.count);
      else passes++;
      step(1, 10);
      for (int i = 0; i < 7; i++) step(1, 6);
      tick(4);
      checks++;
      if (bus4.count !== 4'h7)
         $display("[TB] FAIL wrap_pre_max: count4=%h, required 7", bus4.count);
      else passes++;
      step(1, 10);
      checks++;
      if (bus4.count !== 4'h8 || $signed(bus4.count) != -8 || bus16.count !== 16'h0008)
         $display("[TB] FAIL wrap_signed: count4=%h count16=%h, required 8/0008", bus4.count, bus16.count);
      else passes++;
   endtask

   task automatic test_glitch_illegal();
      logic [15:0] held;
      pulse_clear();
      step(1, 10);
      held = 16'(model_count);
      enc_a = ~enc_a;
      tick(2);
      enc_a = ~enc_a;
      tick(10);
      checks++;
      if (bus16.count !== held || bus16.err !== 1'b0)
         $display("[TB] FAIL glitch: count=%h err=%b, required %h/0", bus16.count, bus16.err, held);
      else passes++;
      pos = (pos + 2) & 3;
      drive_pins();
      tick(10);
      checks++;
      if (bus16.err !== 1'b1 || bus16.count !== held)
         $display("[TB] FAIL illegal_jump: err=%b count=%h, required 1/%h", bus16.err, bus16.count, held);
      else passes++;
      pulse_latch();
      checks++;
      if (bus16.err_snap !== 1'b1 || bus16.count_snap !== held)
         $display("[TB] FAIL err_snap: err_snap=%b snap=%h, required 1/%h", bus16.err_snap, bus16.count_snap, held);
      else passes++;
      pulse_clear();
      checks++;
      if (bus16.err !== 1'b0 || bus16.count !== 16'h0)
         $display("[TB] FAIL clear_err: err=%b count=%h, required 0/0000", bus16.err, bus16.count);
      else passes++;
   endtask

   task automatic test_init_high();
      rst = 1'b1;
      pos = 2;
      drive_pins();
      tick(3);
      rst = 1'b0;
      model_count = 0;
      tick(20);
      checks++;
      if (bus16.count !== 16'h0 || bus16.err !== 1'b0)
         $display("[TB] FAIL init_high: count=%h err=%b, required 0000/0", bus16.count, bus16.err);
      else passes++;
      step(1, 10);
      step(1, 10);
      checks++;
      if (bus16.count !== 16'(model_count) || pos != 0)
         $display("[TB] FAIL init_then_step: count=%h, required %h", bus16.count, 16'(model_count));
      else passes++;
   endtask

   task automatic test_index();
      pulse_clear();
      enc_z = 1'b1;
      tick(10);
      enc_z = 1'b0;
      tick(10);
      checks++;
      if (bus16.index_seen !== 1'b0)
         $display("[TB] FAIL index_unarmed: index_seen=%b, required 0", bus16.index_seen);
      else passes++;
      index_arm = 1'b1;
      tick(1);
      index_arm = 1'b0;
      for (int i = 0; i < 37; i++) step(1, 5);
      tick(5);
      enc_z = 1'b1;
      tick(10);
      checks++;
      if (bus16.index_pos !== 16'd37 || bus16.index_seen !== 1'b1)
         $display("[TB] FAIL index_capture: index_pos=%0d seen=%b, required 37/1", bus16.index_pos, bus16.index_seen);
      else passes++;
      enc_z = 1'b0;
      tick(8);
      for (int i = 0; i < 13; i++) step(1, 5);
      tick(5);
      enc_z = 1'b1;
      tick(10);
      enc_z = 1'b0;
      tick(8);
      checks++;
      if (bus16.index_pos !== 16'd37 || bus16.count !== 16'd50)
         $display("[TB] FAIL index_disarmed: index_pos=%0d count=%0d, required 37/50", bus16.index_pos, bus16.count);
      else passes++;
   endtask

   task automatic test_latch_clear();
      pulse_clear();
      for (int i = 0; i < 100; i++) step(1, 5);
      tick(5);
      pulse_latch();
      checks++;
      if (bus16.count_snap !== 16'd100)
         $display("[TB] FAIL latch_only: count_snap=%0d, required 100", bus16.count_snap);
      else passes++;
      pos = (pos + 1) & 3;
      drive_pins();
      tick(5);
      latch = 1'b1;
      clear = 1'b1;
      tick(1);
      latch = 1'b0;
      clear = 1'b0;
      model_count = 0;
      checks++;
      if (bus16.count !== 16'h0 || bus16.count_snap !== 16'd100 || bus16.index_pos !== 16'd37)
         $display("[TB] FAIL latch_clear: count=%0d snap=%0d idx=%0d, required 0/100/37",
                  bus16.count, bus16.count_snap, bus16.index_pos);
      else passes++;
      tick(10);
      checks++;
      if (bus16.count !== 16'h0 || bus16.index_seen !== 1'b0)
         $display("[TB] FAIL step_lost: count=%0d seen=%b, required 0/0", bus16.count, bus16.index_seen);
      else passes++;
   endtask

   task automatic test_mid_reset();
      step(1, 10);
      step(1, 10);
      index_arm = 1'b1;
      tick(1);
      index_arm = 1'b0;
      pulse_latch();
      rst = 1'b1;
      enc_z = 1'b0;
      tick(2);
      checks++;
      if ({bus16.count, bus16.count_snap, bus16.index_pos, bus16.err, bus16.index_seen} !== '0)
         $display("[TB] FAIL mid_reset: count=%h snap=%h idx=%h err=%b seen=%b, required all 0",
                  bus16.count, bus16.count_snap, bus16.index_pos, bus16.err, bus16.index_seen);
      else passes++;
      rst = 1'b0;
      model_count = 0;
      tick(15);
      enc_z = 1'b1;
      tick(10);
      enc_z = 1'b0;
      checks++;
      if (bus16.count !== 16'h0 || bus16.index_seen !== 1'b0)
         $display("[TB] FAIL mid_reset_disarm: count=%h seen=%b, required 0000/0", bus16.count, bus16.index_seen);
      else passes++;
      tick(8);
   endtask

   task automatic test_random(input bit slow);
      int dir;
      se_mode = slow;
      tick(6);
      for (int i = 0; i < 25; i++) begin
         dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
         if (slow) step(dir, $urandom_range(16, 24));
         else      step(dir, $urandom_range(7, 12));
         checks++;
         if (bus16.count !== 16'(model_count) || bus4.count !== 4'(model_count))
            $display("[TB] FAIL random_%0d_%0d: count16=%h count4=%h, required %h/%h",
                     slow, i, bus16.count, bus4.count, 16'(model_count), 4'(model_count));
         else passes++;
         if ($urandom_range(0, 3) == 0) begin
            pulse_latch();
            checks++;
            if (bus16.count_snap !== 16'(model_count))
               $display("[TB] FAIL random_snap_%0d: count_snap=%h, required %h", i, bus16.count_snap, 16'(model_count));
            else passes++;
         end
      end
      se_mode = 1'b0;
   endtask

   initial begin
      gray_tab[0] = 2'b00;
      gray_tab[1] = 2'b01;
      gray_tab[2] = 2'b11;
      gray_tab[3] = 2'b10;
      test_reset();
      test_latency();
      test_forward_reverse();
      test_wrap();
      test_glitch_illegal();
      test_init_high();
      test_index();
      test_latch_clear();
      test_mid_reset();
      test_random(1'b0);
      test_random(1'b1);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
